serial_deserializer: RTL and testbench

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

---
 rtl/serial_deserializer.sv | 75 +++++++
 tb/tb_serial_deserializer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - LSB-first serial-to-parallel receiver with ack/overrun output stage
module serial_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             shift,
  input  logic             din,
  input  logic             ack,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] next_word;

  assign next_word = {din, sreg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      q       <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // A completing word below overrides this clear of valid when both coincide.
      if (ack && valid) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            state <= RECV;
            busy  <= 1'b1;
          end
        end
        RECV: begin
          if (start) begin
            cnt <= '0;
          end else if (shift) begin
            sreg <= next_word;
            if (cnt == LAST) begin
              q     <= next_word;
              valid <= 1'b1;
              if (valid && !ack)
                overrun <= 1'b1;
              cnt   <= '0;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - table-driven and scoreboard bench for serial_deserializer
module tb_serial_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       shift = 1'b0;
  logic       din = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] q;
  logic       valid;
  logic       busy;
  logic       overrun;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit model_valid = 1'b0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] word;
    int         gap;
    bit         ack_after;
    bit         exp_ovr;
  } vec_t;

  vec_t vecs[8];

  serial_deserializer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .shift(shift), .din(din), .ack(ack),
    .q(q), .valid(valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Start a frame (with a decoy shift on the start cycle), shift 8 bits, check the result.
  task automatic recv(input logic [7:0] w, input int gap, input bit ack_last, input bit exp_ovr);
    logic [7:0] exp_w;
    sb.push_back(w);
    start = 1'b1; shift = 1'b1; din = ~w[0];
    tick();
    start = 1'b0; shift = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      shift = 1'b1; din = w[i];
      if (i == 7 && ack_last) ack = 1'b1;
      tick();
      shift = 1'b0; ack = 1'b0;
      if (i < 7) begin
        if (!model_valid) chk("no_early_valid", valid, 1'b0);
        for (int g = 0; g < gap; g++) tick();
      end
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      exp_w = sb.pop_front();
      chk("q", q, exp_w);
      chk("valid", valid, 1'b1);
      chk("busy_done", busy, 1'b0);
      chk("overrun", overrun, exp_ovr);
    end
    model_valid = 1'b1;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("valid_after_ack", valid, 1'b0);
    chk("overrun_after_ack", overrun, 1'b0);
    model_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 0, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1, 1'b1, 1'b0};
    vecs[2] = '{8'h11, 0, 1'b0, 1'b0};
    vecs[3] = '{8'h22, 2, 1'b1, 1'b1};
    vecs[4] = '{8'hFF, 0, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 3, 1'b1, 1'b0};
    vecs[6] = '{8'h01, 0, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 1, 1'b1, 1'b0};

    #12;
    chk("rst_q", q, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    // Shifts in IDLE are ignored.
    for (int i = 0; i < 4; i++) begin
      shift = 1'b1; din = 1'b1;
      tick();
    end
    shift = 1'b0;
    chk("idle_busy", busy, 1'b0);
    chk("idle_valid", valid, 1'b0);

    for (int v = 0; v < 8; v++) begin
      recv(vecs[v].word, vecs[v].gap, 1'b0, vecs[v].exp_ovr);
      if (vecs[v].ack_after) do_ack();
    end

    // Abort mid-frame by a second start, then a full frame.
    sb.push_back(8'hF0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      shift = 1'b1; din = 1'b1;
      tick();
    end
    start = 1'b1; shift = 1'b1; din = 1'b1;
    tick();
    start = 1'b0; shift = 1'b0;
    chk("abort_busy", busy, 1'b1);
    chk("abort_valid", valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      shift = 1'b1; din = (i >= 4);
      tick();
      if (i < 7) chk("abort_no_valid", valid, 1'b0);
    end
    shift = 1'b0;
    chk("abort_q", q, sb.pop_front());
    chk("abort_valid_done", valid, 1'b1);
    do_ack();

    // Completion coincident with ack: new word loaded, no overrun.
    recv(8'h11, 0, 1'b0, 1'b0);
    recv(8'h5A, 0, 1'b1, 1'b0);
    do_ack();

    // Asynchronous reset mid-frame, then shifts without start.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      shift = 1'b1; din = 1'b1;
      tick();
    end
    shift = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_q", q, 8'h00);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      shift = 1'b1; din = 1'b1;
      tick();
    end
    shift = 1'b0;
    chk("post_rst_valid", valid, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_q", q, 8'h00);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
